// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - bus bundle between the FIFO write controller and its producer/RAM/read side
//
// Purpose: groups the write request, the pointer exchange with the read
// domain, the RAM write port and the status flags of fifo_wr_ctrl.
// Ports (slave = controller side):
//   wt_en        in   producer write request
//   rd_ptr_gray  in   Gray read pointer from the rd_clk domain (asynchronous)
//   wt_ptr_gray  out  registered Gray write pointer to the read domain
//   mem_we       out  RAM write strobe
//   mem_waddr    out  RAM write address
//   full         out  registered full flag
//   wt_level     out  registered pessimistic occupancy, 0..DEPTH
//   overflow     out  sticky write-while-full flag
//   almost_full  out  registered almost-full flag (0 unless enabled)
interface fifo_wr_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          wt_en;
    logic [AW:0]   rd_ptr_gray;
    logic [AW:0]   wt_ptr_gray;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          full;
    logic [AW:0]   wt_level;
    logic          overflow;
    logic          almost_full;

    modport master (
        output wt_en, rd_ptr_gray,
        input  wt_ptr_gray, mem_we, mem_waddr, full, wt_level, overflow, almost_full
    );

    modport slave (
        input  wt_en, rd_ptr_gray,
        output wt_ptr_gray, mem_we, mem_waddr, full, wt_level, overflow, almost_full
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer/flag controller of the dual-clock command FIFO
//
// Purpose: lives in the wt_clk domain. Accepts producer writes, drives the
// FIFO RAM write port, exports a Gray write pointer, imports the read
// domain's Gray pointer through a SYNC_STAGES-flop synchronizer and derives
// full, a pessimistic fill level and a sticky overflow flag.
// Ports:
//   wt_clk   in   write-domain clock
//   rstn     in   asynchronous active-low reset
//   bus      fifo_wr_ctrl_if.slave (wt_en, rd_ptr_gray in; wt_ptr_gray,
//            mem_we, mem_waddr, full, wt_level, overflow, almost_full out)
// Build option: FIFO_WR_ALMOST_FULL_EN enables the registered almost_full
// compare against AFULL_THRESH; otherwise almost_full is tied low.
module fifo_wr_ctrl #(
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic          wt_clk,
    input  logic          rstn,
    fifo_wr_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    // Full when the write pointer is a whole lap ahead: in Gray code this is
    // the synchronized read pointer with its two MSBs inverted.
    localparam logic [AW:0] FULL_MASK = (AW+1)'(3 << (AW - 1));

    logic [AW:0] rq [SYNC_STAGES];
    logic [AW:0] rq_last;
    logic [AW:0] rbin;
    logic [AW:0] wptr_bin;
    logic [AW:0] wnext;
    logic [AW:0] gnext;
    logic [AW:0] level_next;
    logic        acc;

    assign rq_last = rq[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(rq_last >> i);
        end
    end

    assign acc        = bus.wt_en & ~bus.full;
    assign wnext      = wptr_bin + {{AW{1'b0}}, acc};
    assign gnext      = wnext ^ (wnext >> 1);
    assign level_next = wnext - rbin;

    assign bus.mem_we    = acc;
    assign bus.mem_waddr = wptr_bin[AW-1:0];

    always_ff @(posedge wt_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq[i] <= '0;
            end
        end else begin
            rq[0] <= bus.rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq[i] <= rq[i-1];
            end
        end
    end

    always_ff @(posedge wt_clk or negedge rstn) begin
        if (!rstn) begin
            wptr_bin        <= '0;
            bus.wt_ptr_gray <= '0;
            bus.full        <= 1'b0;
            bus.wt_level    <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            wptr_bin        <= wnext;
            bus.wt_ptr_gray <= gnext;
            bus.full        <= (gnext == (rq_last ^ FULL_MASK));
            bus.wt_level    <= level_next;
            bus.overflow    <= bus.overflow | (bus.wt_en & bus.full);
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    always_ff @(posedge wt_clk or negedge rstn) begin
        if (!rstn) begin
            bus.almost_full <= 1'b0;
        end else begin
            bus.almost_full <= (level_next >= (AW+1)'(AFULL_THRESH));
        end
    end
`else
    logic unused_afull_thresh;
    assign unused_afull_thresh = (AFULL_THRESH != 0);
    assign bus.almost_full     = 1'b0;
`endif
endmodule
